// File: rtl/q_result_writer.sv
// q_result_writer: buffers unsigned Q words and streams each one as a decimal ASCII line.
// Define Q_RESULT_WRITER_CRLF_EN for a CR+LF line terminator; the default build emits LF only.
module q_result_writer #(
  parameter int unsigned Q_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [Q_WIDTH-1:0] q_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [7:0]         byte_data,
  output logic               busy,
  output logic [15:0]        line_count
);

  // Smallest digit count whose decimal range covers 2^w - 1.
  function automatic int unsigned calc_digits(input int unsigned w);
    longint unsigned lim;
    longint unsigned p;
    int unsigned     d;
    lim = 64'd1 << w;
    p   = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  localparam int unsigned DIGITS = calc_digits(Q_WIDTH);
  localparam int unsigned BW     = 4 * DIGITS;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned PW     = $clog2(DIGITS);
  localparam int unsigned KW     = $clog2(Q_WIDTH);

`ifdef Q_RESULT_WRITER_CRLF_EN
  localparam bit CRLF_EN = 1'b1;
`else
  localparam bit CRLF_EN = 1'b0;
`endif
  localparam logic [7:0] TERM_FIRST = CRLF_EN ? 8'h0D : 8'h0A;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_EOL} state_e;

  // ASCII character for BCD digit idx.
  function automatic logic [7:0] ascii_at(input logic [BW-1:0] bcd, input logic [PW-1:0] idx);
    logic [3:0] nib;
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (PW'(i) == idx) nib = bcd[4*i +: 4];
    end
    return 8'h30 + {4'h0, nib};
  endfunction

  logic [Q_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               push_c, pop_c, xfer_c;

  state_e             state_q, state_d;
  logic [Q_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [KW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               eol2_q, eol2_d;
  logic               byte_valid_q, byte_valid_d;
  logic [7:0]         byte_data_q, byte_data_d;
  logic [15:0]        line_count_q, line_count_d;
  logic               busy_q;

  logic [BW-1:0]         bcd_adj_c;
  logic [BW+Q_WIDTH-1:0] shifted_c;
  logic [BW-1:0]         bcd_step_c;
  logic [Q_WIDTH-1:0]    bin_step_c;
  logic [PW-1:0]         lead_c;

  assign q_ready    = (count_q != CW'(FIFO_DEPTH));
  assign push_c     = q_valid & q_ready;
  assign xfer_c     = byte_valid_q & byte_ready;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign busy       = busy_q;
  assign line_count = line_count_q;

  // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= q_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // One double-dabble step plus the most significant nonzero digit of its result.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted_c  = {bcd_adj_c, bin_q} << 1;
    bcd_step_c = shifted_c[BW+Q_WIDTH-1:Q_WIDTH];
    bin_step_c = shifted_c[Q_WIDTH-1:0];
    lead_c     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_step_c[4*i +: 4] != 4'd0) lead_c = PW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    eol2_d       = eol2_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;
    line_count_d = line_count_q;
    pop_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          bin_d   = mem_q[rd_ptr_q];
          bcd_d   = '0;
          cnt_d   = KW'(Q_WIDTH - 1);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = bcd_step_c;
        bin_d = bin_step_c;
        if (cnt_q == '0) begin
          state_d      = S_EMIT;
          ptr_d        = lead_c;
          byte_valid_d = 1'b1;
          byte_data_d  = ascii_at(bcd_step_c, lead_c);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EMIT: begin
        if (xfer_c) begin
          if (ptr_q == '0) begin
            state_d     = S_EOL;
            eol2_d      = 1'b0;
            byte_data_d = TERM_FIRST;
          end else begin
            ptr_d       = ptr_q - 1'b1;
            byte_data_d = ascii_at(bcd_q, ptr_q - 1'b1);
          end
        end
      end
      S_EOL: begin
        if (xfer_c) begin
          if (CRLF_EN && !eol2_q) begin
            eol2_d      = 1'b1;
            byte_data_d = 8'h0A;
          end else begin
            byte_valid_d = 1'b0;
            byte_data_d  = 8'h00;
            line_count_d = line_count_q + 16'd1;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      eol2_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      line_count_q <= 16'h0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      eol2_q       <= eol2_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      line_count_q <= line_count_d;
      busy_q       <= (count_q != '0) || (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_q_result_writer.sv
// Scoreboard bench for q_result_writer: accepted words become expected decimal text lines,
// a negedge monitor compares every transferred byte, line_count and stall stability.
module tb_q_result_writer;
  localparam int unsigned Q_WIDTH    = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               q_valid = 1'b0;
  logic               q_ready;
  logic [Q_WIDTH-1:0] q_data = '0;
  logic               byte_valid;
  logic               byte_ready = 1'b0;
  logic [7:0]         byte_data;
  logic               busy;
  logic [15:0]        line_count;

  int          checks = 0;
  int          errors = 0;
  byte unsigned exp_q[$];
  int          exp_lines = 0;
  int          bytes_seen = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          stall_pend = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  bit          pat_run = 1'b0;
  bit          rnd_run = 1'b0;
  logic [15:0] rv;
  int          sel;
  int          ln;
  int          base;
  bit          got;
  byte unsigned exp_b;

  q_result_writer #(.Q_WIDTH(Q_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_data     (q_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .busy       (busy),
    .line_count (line_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the decimal text of the word followed by the line terminator.
  task automatic push_expected(input logic [15:0] v);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef Q_RESULT_WRITER_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("line_count", line_count, exp_lines);
      if (stall_pend) begin
        check("stall_valid", byte_valid, 1);
        check("stall_data", byte_data, stall_data);
      end
      if (q_valid && q_ready) push_expected(q_data);
      if (byte_valid && byte_ready) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte actual=%02h required=none", byte_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte", byte_data, exp_b);
          if (exp_b == 8'h0A) exp_lines++;
        end
      end
      stall_pend = byte_valid && !byte_ready;
      stall_data = byte_data;
    end
  end

  // Called and returns at posedge+1; holds q_valid until the word is accepted.
  task automatic push_word(input logic [15:0] v);
    bit ok;
    ok = 1'b0;
    q_data  = v;
    q_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = q_ready;
      @(posedge clk);
      #1;
    end
    q_valid = 1'b0;
    acc_cyc = cyc;
    check("push_accept", ok, 1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && !busy && !byte_valid;
    end
    check(name, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_q_ready", q_ready, 1);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_busy", busy, 0);
    check("rst_line_count", line_count, 0);
    rst_n = 1'b1;
    byte_ready = 1'b1;
    @(posedge clk);
    #1;

    // Zero emits a single '0'.
    push_word(16'd0);
    drain("t1_drain");
    check("t1_lines", line_count, 1);
    check("t1_busy", busy, 0);

    // First byte_valid rises after edge N+1+Q_WIDTH for a word accepted at edge N.
    push_word(16'd1234);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (byte_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("t2_latency", cyc - acc_cyc, Q_WIDTH + 1);
    for (int i = 0; i < 5; i++) begin
      check("t2_stream", byte_valid, 1);
      @(posedge clk);
      #1;
    end
    drain("t2_drain");
    check("t2_lines", line_count, 2);

    push_word(16'd65535);
    push_word(16'd7);
    drain("t3_drain");
    check("t3_lines", line_count, 4);

    // With the sink stalled, one word moves into the converter and eight more fill the FIFO.
    byte_ready = 1'b0;
    for (int k = 0; k < 9; k++) push_word(16'd100);
    check("t4_q_ready_full", q_ready, 0);
    check("t4_busy", busy, 1);
    pat_run = 1'b1;
    fork
      push_word(16'd100);
      begin
        while (pat_run) begin
          byte_ready = 1'b1;
          @(posedge clk);
          #1;
          byte_ready = 1'b0;
          repeat (2) begin
            @(posedge clk);
            #1;
          end
        end
        byte_ready = 1'b1;
      end
      begin
        drain("t4_drain");
        pat_run = 1'b0;
      end
    join
    check("t4_lines", line_count, 14);

    push_word(16'd42);
    drain("t5_drain");
    check("t5_lines", line_count, 15);
    ln = 15;

    rnd_run = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          sel = int'($urandom_range(0, 9));
          if (sel == 0)      rv = 16'd0;
          else if (sel == 1) rv = 16'hFFFF;
          else if (sel == 2) rv = 16'($urandom_range(0, 9));
          else               rv = 16'($urandom);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          push_word(rv);
        end
        drain("rnd_drain");
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          byte_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        byte_ready = 1'b1;
      end
    join
    ln += 40;
    check("rnd_lines", line_count, ln);

    // Reset after "12" of 12345 has transferred; the queued 678 is discarded too.
    push_word(16'd12345);
    push_word(16'd678);
    base = bytes_seen;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      got = (bytes_seen >= base + 2);
    end
    check("rst_mid_reached", got, 1);
    check("rst_mid_pre_valid", byte_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    exp_lines = 0;
    stall_pend = 1'b0;
    #1;
    check("rst_mid_valid", byte_valid, 0);
    check("rst_mid_data", byte_data, 0);
    check("rst_mid_lines", line_count, 0);
    check("rst_mid_q_ready", q_ready, 1);
    check("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_word(16'd5);
    drain("t6_drain");
    check("t6_lines", line_count, 1);
    check("t6_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
